matrix_serializer: RTL

Sequential companion to the combinational matrix multiplier. It captures one flattened M×O result matrix in a single handshake and streams it out one element per beat over a valid/ready interface, tagged with row/column indices and a last flag. It sits between the multiplier output and narrow consumers such as FIFOs, UART/bus bridges or accumulators.

---
 rtl/matrix_serializer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/matrix_serializer.sv
// matrix_serializer: captures one flattened M x O matrix in a single
// handshake and streams it out one element per beat (valid/ready), tagged
// with row/column indices and a last flag. Scan order is row-major or
// column-major depending on COL_MAJOR.
module matrix_serializer #(
    parameter int M          = 32,
    parameter int O          = 1,
    parameter int DATA_WIDTH = 16,
    parameter int COL_MAJOR  = 0,
    parameter int RW         = (M > 1) ? $clog2(M) : 1,
    parameter int CW         = (O > 1) ? $clog2(O) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [M*O*DATA_WIDTH-1:0]    mat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [RW-1:0]                out_row,
    output logic [CW-1:0]                out_col,
    output logic                         out_last
);

    localparam int            TOTAL_W = M * O * DATA_WIDTH;
    localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(O - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [TOTAL_W-1:0]   shadow_r;
    logic [TOTAL_W-1:0]   shifted_s;
    logic [RW-1:0]        row_r;
    logic [RW-1:0]        row_nxt_s;
    logic [CW-1:0]        col_r;
    logic [CW-1:0]        col_nxt_s;
    logic                 accept_s;
    logic                 at_last_s;
    int                   idx_s;

    // Handshake qualifiers and outputs decoded purely from registered state.
    assign accept_s   = (state_r == ST_STREAM) && out_ready;
    assign at_last_s  = (row_r == ROW_MAX) && (col_r == COL_MAX);
    assign load_ready = (state_r == ST_IDLE);
    assign out_valid  = (state_r == ST_STREAM);
    assign out_last   = (state_r == ST_STREAM) && at_last_s;
    assign out_row    = row_r;
    assign out_col    = col_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: capture in IDLE, leave STREAM once the final beat is taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_valid) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && at_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Index advance for one accepted beat; the final beat wraps both to 0.
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        if (COL_MAJOR != 0) begin
            if (row_r == ROW_MAX) begin
                row_nxt_s = {RW{1'b0}};
                if (col_r == COL_MAX) begin
                    col_nxt_s = {CW{1'b0}};
                end else begin
                    col_nxt_s = col_r + CW'(1);
                end
            end else begin
                row_nxt_s = row_r + RW'(1);
            end
        end else begin
            if (col_r == COL_MAX) begin
                col_nxt_s = {CW{1'b0}};
                if (row_r == ROW_MAX) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = row_r + RW'(1);
                end
            end else begin
                col_nxt_s = col_r + CW'(1);
            end
        end
    end

    // Shadow capture and row/column counters; shadow changes only on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {TOTAL_W{1'b0}};
            row_r    <= {RW{1'b0}};
            col_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_valid) begin
                        shadow_r <= mat;
                        row_r    <= {RW{1'b0}};
                        col_r    <= {CW{1'b0}};
                    end else begin
                        shadow_r <= shadow_r;
                        row_r    <= row_r;
                        col_r    <= col_r;
                    end
                end
                ST_STREAM: begin
                    shadow_r <= shadow_r;
                    if (accept_s) begin
                        row_r <= row_nxt_s;
                        col_r <= col_nxt_s;
                    end else begin
                        row_r <= row_r;
                        col_r <= col_r;
                    end
                end
                default: begin
                    shadow_r <= {TOTAL_W{1'b0}};
                    row_r    <= {RW{1'b0}};
                    col_r    <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Element select: element (i,j) sits i*O+j slots below the MSB end.
    always_comb begin
        idx_s     = int'(row_r) * O + int'(col_r);
        shifted_s = shadow_r << (idx_s * DATA_WIDTH);
        out_data  = shifted_s[TOTAL_W-1 -: DATA_WIDTH];
    end

endmodule
